// File: rtl/pll_drp_pkg.sv
// Shared definitions for the PLLE2_ADV DRP reprogramming sequencer:
// FSM state encoding, error codes, DRP register addresses, preserve masks
// and the legal ranges of the divide/multiply values.
package pll_drp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RD_REQ    = 4'd1,
        ST_RD_WAIT   = 4'd2,
        ST_WR_REQ    = 4'd3,
        ST_WR_WAIT   = 4'd4,
        ST_VFY_REQ   = 4'd5,
        ST_VFY_WAIT  = 4'd6,
        ST_RELEASE   = 4'd7,
        ST_LOCK_WAIT = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_DRDY_TIMEOUT = 2'd1,
        ERR_LOCK_TIMEOUT = 2'd2,
        ERR_INVALID      = 2'd3
    } err_code_t;

    // Which merge rule applies to the register currently being programmed.
    typedef enum logic [1:0] {
        KIND_REG1   = 2'd0,
        KIND_REG2   = 2'd1,
        KIND_DIVCLK = 2'd2
    } reg_kind_t;

    // Reg1 addresses of the output dividers; Reg2 is always Reg1 + 1.
    localparam logic [6:0] ADDR_CLKOUT0_R1 = 7'h08;
    localparam logic [6:0] ADDR_CLKOUT1_R1 = 7'h0A;
    localparam logic [6:0] ADDR_CLKOUT2_R1 = 7'h0C;
    localparam logic [6:0] ADDR_CLKOUT3_R1 = 7'h0E;
    localparam logic [6:0] ADDR_CLKOUT4_R1 = 7'h10;
    localparam logic [6:0] ADDR_CLKOUT5_R1 = 7'h06;
    localparam logic [6:0] ADDR_CLKFB_R1   = 7'h14;
    localparam logic [6:0] ADDR_CLKFB_R2   = 7'h15;
    localparam logic [6:0] ADDR_DIVCLK     = 7'h16;

    // Bits of the old register contents that must survive the rewrite.
    localparam logic [15:0] MASK_REG1   = 16'h1000;
    localparam logic [15:0] MASK_REG2   = 16'hFF00;
    localparam logic [15:0] MASK_DIVCLK = 16'hC000;

    // Legal value ranges.
    localparam logic [6:0] DIV_MIN    = 7'd1;
    localparam logic [6:0] DIV_MAX    = 7'd126;
    localparam logic [6:0] MULT_MIN   = 7'd2;
    localparam logic [6:0] MULT_MAX   = 7'd64;
    localparam logic [6:0] DIVCLK_MIN = 7'd1;
    localparam logic [6:0] DIVCLK_MAX = 7'd56;

    // Reg1 address of CLKOUTn.
    function automatic logic [6:0] clkout_reg1_addr(input int n);
        case (n)
            0:       return ADDR_CLKOUT0_R1;
            1:       return ADDR_CLKOUT1_R1;
            2:       return ADDR_CLKOUT2_R1;
            3:       return ADDR_CLKOUT3_R1;
            4:       return ADDR_CLKOUT4_R1;
            default: return ADDR_CLKOUT5_R1;
        endcase
    endfunction

endpackage

// File: rtl/pll_drp_divcalc.sv
// Divide value to PLL counter fields: high = floor(d/2), low = d - high,
// edge = d odd, no_count = (d == 1). A divide of 1 is coded high = low = 1.
module pll_drp_divcalc (
    input  logic [6:0] div_val,
    output logic [5:0] high_cnt,
    output logic [5:0] low_cnt,
    output logic       edge_bit,
    output logic       no_count
);

    // Split the divide value into counter high/low times and flag bits.
    always_comb begin
        no_count = (div_val == 7'd1);
        edge_bit = div_val[0];
        if (no_count) begin
            high_cnt = 6'd1;
            low_cnt  = 6'd1;
        end else begin
            high_cnt = div_val[6:1];
            // d - floor(d/2) is ceil(d/2)
            low_cnt  = div_val[6:1] + {5'd0, div_val[0]};
        end
    end

endmodule

// File: rtl/pll_drp_sequencer.sv
// DRP reconfiguration sequencer for one PLLE2_ADV: holds the PLL in reset,
// read-modify-writes every output divider, the feedback multiplier and the
// input divider, then releases reset and waits for LOCKED.
// Build option PLL_DRP_READBACK_EN adds a verify read after every write.
// DRP handshake: DEN (with DWE for writes) is a one-cycle pulse; the
// transaction completes on the first DRDY seen from the cycle after DEN,
// and DADDR/DI stay stable until that DRDY. DRDY elsewhere is ignored.
module pll_drp_sequencer
    import pll_drp_pkg::*;
#(
    parameter int NUM_OUT      = 6,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                 DCLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic [7*NUM_OUT-1:0] CLKOUT_DIV,
    input  logic [6:0]           CLKFBOUT_MULT,
    input  logic [6:0]           DIVCLK_DIVIDE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERROR,
    output logic [1:0]           ERR_CODE,
    output logic                 PLL_RST,
    output logic [6:0]           DADDR,
    output logic                 DEN,
    output logic                 DWE,
    output logic [15:0]          DI,
    input  logic [15:0]          DO,
    input  logic                 DRDY,
    input  logic                 LOCKED,
    output logic [3:0]           DBG_STATE
);

    localparam int NREG = 2 * NUM_OUT + 3;
    localparam int IW   = $clog2(NREG);
    localparam int TMAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int CW   = $clog2(TMAX + 1);

    state_t               state_q, state_d;
    logic [7*NUM_OUT-1:0] div_q, div_d;
    logic [6:0]           mult_q, mult_d;
    logic [6:0]           divclk_q, divclk_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [15:0]          old_q, old_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    err_code_t            code_q, code_d;

    logic                 inputs_ok;
    logic [6:0]           div_sel;
    logic [6:0]           addr_sel;
    reg_kind_t            kind_sel;
    logic [5:0]           high_cnt, low_cnt;
    logic                 edge_bit, no_count;
    logic [15:0]          merged;
    logic                 is_last;
    logic                 drdy_expired;
    logic                 lock_expired;
    logic                 drp_phase;

    assign is_last      = (idx_q == IW'(NREG - 1));
    assign drdy_expired = (cnt_q == CW'(DRDY_TIMEOUT - 1));
    assign lock_expired = (cnt_q == CW'(LOCK_TIMEOUT - 1));

    // Range check of the live request inputs, used when START is accepted.
    always_comb begin
        inputs_ok = 1'b1;
        for (int n = 0; n < NUM_OUT; n++) begin
            if (CLKOUT_DIV[7*n +: 7] < DIV_MIN || CLKOUT_DIV[7*n +: 7] > DIV_MAX)
                inputs_ok = 1'b0;
        end
        if (CLKFBOUT_MULT < MULT_MIN || CLKFBOUT_MULT > MULT_MAX)
            inputs_ok = 1'b0;
        if (DIVCLK_DIVIDE < DIVCLK_MIN || DIVCLK_DIVIDE > DIVCLK_MAX)
            inputs_ok = 1'b0;
    end

    // Map the register index onto address, divide value and merge rule.
    always_comb begin
        div_sel  = mult_q;
        addr_sel = ADDR_CLKFB_R1;
        kind_sel = KIND_REG1;
        for (int n = 0; n < NUM_OUT; n++) begin
            if (idx_q == IW'(2*n)) begin
                div_sel  = div_q[7*n +: 7];
                addr_sel = clkout_reg1_addr(n);
                kind_sel = KIND_REG1;
            end else if (idx_q == IW'(2*n + 1)) begin
                div_sel  = div_q[7*n +: 7];
                addr_sel = clkout_reg1_addr(n) + 7'd1;
                kind_sel = KIND_REG2;
            end
        end
        if (idx_q == IW'(2*NUM_OUT + 1)) begin
            div_sel  = mult_q;
            addr_sel = ADDR_CLKFB_R2;
            kind_sel = KIND_REG2;
        end else if (idx_q == IW'(2*NUM_OUT + 2)) begin
            div_sel  = divclk_q;
            addr_sel = ADDR_DIVCLK;
            kind_sel = KIND_DIVCLK;
        end
    end

    pll_drp_divcalc u_divcalc (
        .div_val  (div_sel),
        .high_cnt (high_cnt),
        .low_cnt  (low_cnt),
        .edge_bit (edge_bit),
        .no_count (no_count)
    );

    // Merge the new counter fields into the preserved bits of the old value.
    always_comb begin
        case (kind_sel)
            KIND_REG2:   merged = (old_q & MASK_REG2) | {8'h00, edge_bit, no_count, 6'h00};
            KIND_DIVCLK: merged = (old_q & MASK_DIVCLK) | {2'b00, edge_bit, no_count, high_cnt, low_cnt};
            default:     merged = (old_q & MASK_REG1) | {4'h0, high_cnt, low_cnt};
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge DCLK) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            mult_q   <= '0;
            divclk_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            old_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            mult_q   <= mult_d;
            divclk_q <= divclk_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            old_q    <= old_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    // Next-state logic of the sequencing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (START && inputs_ok) state_d = ST_RD_REQ;
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (DRDY)              state_d = ST_WR_REQ;
                else if (drdy_expired) state_d = ST_IDLE;
            end
            ST_WR_REQ:  state_d = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (DRDY) begin
`ifdef PLL_DRP_READBACK_EN
                    state_d = ST_VFY_REQ;
`else
                    state_d = is_last ? ST_RELEASE : ST_RD_REQ;
`endif
                end else if (drdy_expired) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef PLL_DRP_READBACK_EN
            ST_VFY_REQ:  state_d = ST_VFY_WAIT;
            ST_VFY_WAIT: begin
                if (DRDY)              state_d = (DO == merged) ? (is_last ? ST_RELEASE : ST_RD_REQ) : ST_IDLE;
                else if (drdy_expired) state_d = ST_IDLE;
            end
`endif
            ST_RELEASE:   state_d = ST_LOCK_WAIT;
            ST_LOCK_WAIT: if (LOCKED || lock_expired) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Datapath updates: request latch, timeout counter, capture and status.
    always_comb begin
        div_d    = div_q;
        mult_d   = mult_q;
        divclk_d = divclk_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        old_d    = old_q;
        done_d   = 1'b0;
        err_d    = err_q;
        code_d   = code_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    div_d    = CLKOUT_DIV;
                    mult_d   = CLKFBOUT_MULT;
                    divclk_d = DIVCLK_DIVIDE;
                    idx_d    = '0;
                    err_d    = !inputs_ok;
                    code_d   = inputs_ok ? ERR_NONE : ERR_INVALID;
                end
            end
            ST_RD_REQ, ST_WR_REQ, ST_VFY_REQ, ST_RELEASE: cnt_d = CW'(1);
            ST_RD_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (DRDY) begin
                    old_d = DO;
                end else if (drdy_expired) begin
                    err_d  = 1'b1;
                    code_d = ERR_DRDY_TIMEOUT;
                end
            end
            ST_WR_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (DRDY) begin
`ifndef PLL_DRP_READBACK_EN
                    idx_d = idx_q + IW'(1);
`endif
                end else if (drdy_expired) begin
                    err_d  = 1'b1;
                    code_d = ERR_DRDY_TIMEOUT;
                end
            end
`ifdef PLL_DRP_READBACK_EN
            ST_VFY_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (DRDY) begin
                    if (DO == merged) begin
                        idx_d = idx_q + IW'(1);
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_INVALID;
                    end
                end else if (drdy_expired) begin
                    err_d  = 1'b1;
                    code_d = ERR_DRDY_TIMEOUT;
                end
            end
`endif
            ST_LOCK_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (LOCKED) begin
                    done_d = 1'b1;
                end else if (lock_expired) begin
                    err_d  = 1'b1;
                    code_d = ERR_LOCK_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // Moore outputs decoded from the current state and status flops.
    always_comb begin
        drp_phase = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) ||
                    (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT) ||
                    (state_q == ST_VFY_REQ) || (state_q == ST_VFY_WAIT);
        BUSY      = (state_q != ST_IDLE);
        PLL_RST   = drp_phase;
        DEN       = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ) || (state_q == ST_VFY_REQ);
        DWE       = (state_q == ST_WR_REQ);
        DADDR     = drp_phase ? addr_sel : 7'h00;
        DI        = ((state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT)) ? merged : 16'h0000;
        DONE      = done_q;
        ERROR     = err_q;
        ERR_CODE  = code_q;
        DBG_STATE = state_q;
    end

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Bench for pll_drp_sequencer: behavioural DRP register file and LOCKED
// model, expected write list computed from the divider encoding rules.
module tb_pll_drp_sequencer;
    import pll_drp_pkg::*;

    localparam int NUM_OUT = 6;
    localparam int DRDY_TO = 64;
    localparam int LOCK_TO = 4096;
    localparam int NREG    = 2 * NUM_OUT + 3;
`ifdef PLL_DRP_READBACK_EN
    localparam int TXN_PER_REG = 3;
`else
    localparam int TXN_PER_REG = 2;
`endif

    logic                 DCLK;
    logic                 RST_N;
    logic                 START;
    logic [7*NUM_OUT-1:0] CLKOUT_DIV;
    logic [6:0]           CLKFBOUT_MULT;
    logic [6:0]           DIVCLK_DIVIDE;
    logic                 BUSY, DONE, ERROR, PLL_RST, DEN, DWE, DRDY, LOCKED;
    logic [1:0]           ERR_CODE;
    logic [6:0]           DADDR;
    logic [15:0]          DI, DO;
    logic [3:0]           DBG_STATE;

    pll_drp_sequencer #(
        .NUM_OUT(NUM_OUT), .DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .DCLK(DCLK), .RST_N(RST_N), .START(START), .CLKOUT_DIV(CLKOUT_DIV),
        .CLKFBOUT_MULT(CLKFBOUT_MULT), .DIVCLK_DIVIDE(DIVCLK_DIVIDE),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERR_CODE(ERR_CODE),
        .PLL_RST(PLL_RST), .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI),
        .DO(DO), .DRDY(DRDY), .LOCKED(LOCKED), .DBG_STATE(DBG_STATE)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] mem [0:127];
    logic [22:0] exp_q[$];
    logic [22:0] wr_q[$];
    int          dens = 0;
    int          withhold_at = -1;
    int          pending = 0;
    int          den_mark_cyc = 0;
    int          rel_cyc = 0;
    int          end_cyc = 0;
    logic [6:0]  rd_addr = '0;
    bit          lock_follow = 1'b1;
    int          lock_cnt = 0;
    int          lock_delay = 4;
    logic        prev_rst = 1'b0;
    logic        first_err, first_busy;
    int          addr_tab [0:5] = '{8, 10, 12, 14, 16, 6};

    // clock / reset block
    initial DCLK = 1'b0;
    always #5 DCLK = ~DCLK;
    always @(posedge DCLK) cyc = cyc + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // DRP register file: answers each DEN after 1..3 cycles, logs writes
    always @(negedge DCLK) begin
        if (pending > 0) begin
            pending = pending - 1;
            if (pending == 0) begin
                DRDY = 1'b1;
                DO   = mem[rd_addr];
            end else begin
                DRDY = 1'b0;
            end
        end else begin
            DRDY = 1'b0;
        end
        if (DEN === 1'b1) begin
            dens = dens + 1;
            if (DWE === 1'b1) begin
                mem[DADDR] = DI;
                wr_q.push_back({DADDR, DI});
            end
            rd_addr = DADDR;
            if (dens == withhold_at) den_mark_cyc = cyc;
            else                     pending = $urandom_range(1, 3);
        end
    end

    // LOCKED model: rises some cycles after PLL_RST falls, or stays low
    always @(negedge DCLK) begin
        if (prev_rst === 1'b1 && PLL_RST === 1'b0) rel_cyc = cyc;
        prev_rst = PLL_RST;
        if (PLL_RST !== 1'b0 || !lock_follow) begin
            lock_cnt = 0;
            LOCKED   = 1'b0;
        end else if (lock_cnt < lock_delay) begin
            lock_cnt = lock_cnt + 1;
        end else begin
            LOCKED = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference encoding from the divider rules.
    function automatic logic [15:0] ref_reg1(input logic [15:0] old, input int d);
        int hi, lo;
        hi = d / 2; lo = d - hi;
        if (d == 1) begin hi = 1; lo = 1; end
        return (old & 16'h1000) | 16'(hi * 64 + lo);
    endfunction

    function automatic logic [15:0] ref_reg2(input logic [15:0] old, input int d);
        return (old & 16'hFF00) | 16'(((d % 2) * 128) + ((d == 1) ? 64 : 0));
    endfunction

    function automatic logic [15:0] ref_divclk(input logic [15:0] old, input int d);
        int hi, lo;
        hi = d / 2; lo = d - hi;
        if (d == 1) begin hi = 1; lo = 1; end
        return (old & 16'hC000) | 16'((d % 2) * 8192 + ((d == 1) ? 4096 : 0) + hi * 64 + lo);
    endfunction

    task automatic build_exp(input logic [7*NUM_OUT-1:0] divs, input int mult, input int dclk);
        int a, d;
        exp_q.delete();
        for (int n = 0; n < NUM_OUT; n++) begin
            a = addr_tab[n];
            d = int'(divs[7*n +: 7]);
            exp_q.push_back({7'(a), ref_reg1(mem[a], d)});
            exp_q.push_back({7'(a + 1), ref_reg2(mem[a + 1], d)});
        end
        exp_q.push_back({7'h14, ref_reg1(mem[8'h14], mult)});
        exp_q.push_back({7'h15, ref_reg2(mem[8'h15], mult)});
        exp_q.push_back({7'h16, ref_divclk(mem[8'h16], dclk)});
    endtask

    // driver: one request, returns 1 done / 2 error / 0 budget expired
    task automatic run(input logic [7*NUM_OUT-1:0] divs, input logic [6:0] mult,
                       input logic [6:0] dclk, input int budget, input bit poke,
                       output int outcome);
        dens = 0;
        wr_q.delete();
        lock_delay = $urandom_range(2, 15);
        @(negedge DCLK);
        CLKOUT_DIV = divs; CLKFBOUT_MULT = mult; DIVCLK_DIVIDE = dclk; START = 1'b1;
        @(negedge DCLK);
        START = 1'b0;
        first_err  = ERROR;
        first_busy = BUSY;
        outcome = 0;
        for (int i = 0; i < budget; i++) begin
            if (DONE === 1'b1)  begin outcome = 1; end_cyc = cyc; break; end
            if (ERROR === 1'b1) begin outcome = 2; end_cyc = cyc; break; end
            @(negedge DCLK);
            START = poke && (i == 20 || i == 45);
        end
        START = 1'b0;
    endtask

    task automatic score(input string tag);
        check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) check({tag, "_wr"}, wr_q[i], exp_q[i]);
        check({tag, "_dens"}, dens, NREG * TXN_PER_REG);
    endtask

    function automatic logic [7*NUM_OUT-1:0] rand_divs();
        logic [7*NUM_OUT-1:0] v;
        for (int n = 0; n < NUM_OUT; n++) v[7*n +: 7] = 7'($urandom_range(1, 126));
        return v;
    endfunction

    initial begin
        logic [7*NUM_OUT-1:0] divs;
        logic [6:0]  m, dv;
        logic [22:0] w;
        int outcome;
        bit found;

        RST_N = 1'b0; START = 1'b0; DRDY = 1'b0; DO = '0; LOCKED = 1'b0;
        CLKOUT_DIV = '0; CLKFBOUT_MULT = 7'd8; DIVCLK_DIVIDE = 7'd1;
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);

        // reset state
        repeat (3) @(negedge DCLK);
        check("rst_status", {BUSY, DONE, ERROR, ERR_CODE, PLL_RST}, 0);
        check("rst_drp", {DEN, DWE, DADDR, DI}, 0);
        RST_N = 1'b1;
        @(negedge DCLK);
        check("idle_status", {BUSY, DONE, ERROR, ERR_CODE, PLL_RST, DEN}, 0);

        // CLKOUT0 divide 5 over old Reg1 0x1000
        divs = rand_divs(); divs[6:0] = 7'd5; mem[8'h08] = 16'h1000;
        m = 7'($urandom_range(2, 64)); dv = 7'($urandom_range(1, 56));
        build_exp(divs, int'(m), int'(dv));
        run(divs, m, dv, 2000, 1'b0, outcome);
        check("a_outcome", outcome, 1);
        check("a_first_busy", first_busy, 1);
        check("a_done_err", {ERROR, ERR_CODE, BUSY}, 0);
        @(negedge DCLK);
        check("a_done_pulse", DONE, 0);
        score("a");
        w = wr_q[0]; check("a_reg08", w, {7'h08, 16'h1083});
        w = wr_q[1]; check("a_reg09_edge", w[7], 1);

        // CLKOUT1 divide 1, then 4
        divs = rand_divs(); divs[13:7] = 7'd1;
        build_exp(divs, 8, 2);
        run(divs, 7'd8, 7'd2, 2000, 1'b0, outcome);
        check("b_outcome", outcome, 1);
        score("b");
        w = wr_q[3]; check("b_0b_nocount", w[6], 1);
        w = wr_q[2]; check("b_0a_low", w[11:0], 12'h041);
        divs[13:7] = 7'd4;
        build_exp(divs, 8, 2);
        run(divs, 7'd8, 7'd2, 2000, 1'b0, outcome);
        check("c_outcome", outcome, 1);
        score("c");
        w = wr_q[2]; check("c_0a_low", w[11:0], 12'h082);
        w = wr_q[3]; check("c_0b_flags", w[7:6], 2'b00);

        // range boundaries, then random with START pulsed while busy
        for (int k = 0; k < 3; k++) begin
            if (k == 0)      begin divs = {NUM_OUT{7'd126}}; m = 7'd64; dv = 7'd56; end
            else if (k == 1) begin divs = {NUM_OUT{7'd1}};   m = 7'd2;  dv = 7'd1;  end
            else begin divs = rand_divs(); m = 7'($urandom_range(2, 64)); dv = 7'($urandom_range(1, 56)); end
            build_exp(divs, int'(m), int'(dv));
            run(divs, m, dv, 2000, k == 2, outcome);
            check("d_outcome", outcome, 1);
            score("d");
        end

        // DRDY withheld on the third transaction
        withhold_at = 3;
        run(rand_divs(), 7'd10, 7'd3, 500, 1'b0, outcome);
        withhold_at = -1;
        check("e_outcome", outcome, 2);
        check("e_code", ERR_CODE, 1);
        check("e_latency", end_cyc - den_mark_cyc, DRDY_TO);
        check("e_idle", {PLL_RST, BUSY, DONE}, 0);

        // out-of-range requests
        for (int k = 0; k < 6; k++) begin
            divs = rand_divs(); m = 7'd20; dv = 7'd4;
            case (k)
                0: m = 7'd1;
                1: m = 7'd65;
                2: dv = 7'd0;
                3: dv = 7'd57;
                4: divs[27:21] = 7'd0;
                default: divs[41:35] = 7'd127;
            endcase
            run(divs, m, dv, 5, 1'b0, outcome);
            check("f_error", {first_err, ERR_CODE}, {1'b1, 2'd3});
            check("f_no_start", {first_busy, BUSY, PLL_RST}, 0);
            repeat (10) @(negedge DCLK);
            check("f_no_den", dens, 0);
        end

        // lock timeout, then recovery
        lock_follow = 1'b0;
        run(rand_divs(), 7'd30, 7'd5, 6000, 1'b0, outcome);
        check("g_outcome", outcome, 2);
        check("g_code", ERR_CODE, 2);
        check("g_latency", end_cyc - rel_cyc, LOCK_TO);
        check("g_idle", {BUSY, PLL_RST, DONE}, 0);
        lock_follow = 1'b1;
        divs = rand_divs();
        build_exp(divs, 12, 7);
        run(divs, 7'd12, 7'd7, 2000, 1'b0, outcome);
        check("g2_cleared", {first_err, first_busy}, 2'b01);
        check("g2_outcome", outcome, 1);
        check("g2_code", {ERROR, ERR_CODE}, 0);
        score("g2");

        // reset during WR_WAIT
        dens = 0;
        @(negedge DCLK);
        CLKOUT_DIV = rand_divs(); CLKFBOUT_MULT = 7'd9; DIVCLK_DIVIDE = 7'd2; START = 1'b1;
        @(negedge DCLK);
        START = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (DEN === 1'b1 && DWE === 1'b1) begin found = 1'b1; break; end
            @(negedge DCLK);
        end
        check("h_write_seen", found, 1);
        @(negedge DCLK);
        check("h_in_wr_wait", DBG_STATE, ST_WR_WAIT);
        RST_N = 1'b0;
        @(posedge DCLK); #1;
        check("h_rst_status", {BUSY, DONE, ERROR, ERR_CODE, PLL_RST}, 0);
        check("h_rst_drp", {DEN, DWE, DADDR, DI}, 0);
        @(negedge DCLK);
        RST_N = 1'b1;
        repeat (5) @(negedge DCLK);
        check("h_stays_idle", {BUSY, DEN, PLL_RST}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
